ap_acc_arb: RTL and testbench

Round-robin scheduler that shares one 16-bit approximate segmented-carry adder (`i_ap_adder`) among `N_REQ` accumulation channels. Each channel streams 16-bit operands, framed by a `last` flag, into its own private accumulator. The block serialises the channels onto the single adder one operand per cycle and returns each finished approximate sum on a shared valid/ready result port tagged with the channel ID. It sits between the RBM neuron input stages and the activation logic.

---
 rtl/ap_acc_pkg.sv | 20 ++
 rtl/ap_acc_arb_rr_arb.sv | 38 +++
 rtl/ap_adder.sv | 17 +
 rtl/ap_acc_arb.sv | 155 +++++++++++++++
 tb/tb_ap_acc_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_acc_pkg.sv
// Shared constants and helpers for the approximate accumulator arbiter.
package ap_acc_pkg;

  // Operand / accumulator width.
  localparam int DATA_W = 16;

  // Width of one carry segment in the approximate adder. Carries never
  // cross a segment boundary.
  localparam int SEG_W = 4;

  // Value an accumulator returns to at reset and after a packet completes.
  localparam logic [DATA_W-1:0] ACC_ZERO = '0;

  // Round-robin pointer advance: the slot after the one just served,
  // wrapping at n.
  function automatic int rr_advance(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ap_acc_arb_rr_arb.sv
// Combinational round-robin picker: the first eligible requester found
// scanning ptr, ptr+1, ... modulo N_REQ wins.
module rr_arb
  import ap_acc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);

  int               scan_idx;
  logic [N_REQ-1:0] elig_sh;

  // Scan from the farthest slot back to ptr so the nearest eligible slot
  // is the last one written and therefore wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = 0;
    elig_sh  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(ptr) + k) % N_REQ;
      elig_sh  = eligible >> scan_idx;
      if (elig_sh[0]) begin
        grant   = N_REQ'(1) << scan_idx;
        gnt_idx = ID_W'(scan_idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ap_adder.sv
// Segmented-carry approximate adder. Each SEG_W-bit segment is summed on
// its own and its carry-out is discarded, so no carry ripples between
// segments. There is no overall carry-out and no saturation.
module ap_adder
  import ap_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  for (genvar s = 0; s < DATA_W / SEG_W; s++) begin : g_seg
    // Same-width add truncates the segment carry.
    assign sum[s*SEG_W +: SEG_W] = a[s*SEG_W +: SEG_W] + b[s*SEG_W +: SEG_W];
  end

endmodule

// File: rtl/ap_acc_arb.sv
// Round-robin scheduler sharing one approximate adder among N_REQ
// accumulation channels. Each channel owns a private accumulator; a
// finished packet sum is presented on a single result register tagged
// with its channel ID.
//
// Handshakes: a transfer happens on a cycle where VALID and READY are both
// high at the rising clock edge. A source holds VALID and its payload
// stable until the transfer; READY may depend on VALID but VALID never
// depends on READY. REQ_READY is combinational from REQ_VALID, REQ_LAST,
// OUT_READY and internal state.
module ap_acc_arb
  import ap_acc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        REQ_VALID,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]        REQ_LAST,
  output logic [N_REQ-1:0]        REQ_READY,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [DATA_W-1:0]       OUT_SUM,
  output logic [ID_W-1:0]         OUT_ID,
  output logic [N_REQ-1:0]        IN_PKT
);

  // Per-channel state.
  logic [DATA_W-1:0] acc_q [N_REQ];
  logic [DATA_W-1:0] acc_d [N_REQ];
  logic [N_REQ-1:0]  in_pkt_q, in_pkt_d;

  // Shared state.
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_sum_q, out_sum_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  // Arbitration and datapath.
  logic              out_free;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              gnt_last;
  logic [DATA_W-1:0] add_a, add_b, add_sum;

  // A last operand may only be taken when the result register can accept
  // it this cycle (empty, or being drained right now). Non-last operands
  // never touch the result register and are always eligible when valid.
  assign out_free = !out_valid_q || OUT_READY;
  assign eligible = REQ_VALID & (~REQ_LAST | {N_REQ{out_free}});

  rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // Steer the granted channel's accumulator and operand onto the adder.
  always_comb begin
    add_a    = ACC_ZERO;
    add_b    = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        add_a    = acc_q[i];
        add_b    = REQ_DATA[i*DATA_W +: DATA_W];
        gnt_last = REQ_LAST[i];
      end
    end
  end

  ap_adder i_ap_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Next-state: update only the granted channel, load the result register
  // on a last, and advance the pointer past whoever was served.
  always_comb begin
    acc_d       = acc_q;
    in_pkt_d    = in_pkt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        if (REQ_LAST[i]) begin
          acc_d[i]    = ACC_ZERO;
          in_pkt_d[i] = 1'b0;
        end else begin
          acc_d[i]    = add_sum;
          in_pkt_d[i] = 1'b1;
        end
      end
    end

    // A last accepted in the same cycle as a drain reloads the register,
    // giving back-to-back results with no bubble.
    if (gnt_any && gnt_last) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_id_d    = gnt_idx;
    end

    if (gnt_any) begin
      ptr_d = ID_W'(rr_advance(int'(gnt_idx), N_REQ));
    end
  end

  // State registers; reset discards any partial sums.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_REQ; i++) begin
        acc_q[i] <= ACC_ZERO;
      end
      in_pkt_q    <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        acc_q[i] <= acc_d[i];
      end
      in_pkt_q    <= in_pkt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
    end
  end

  assign REQ_READY = grant;
  assign OUT_VALID = out_valid_q;
  assign OUT_SUM   = out_sum_q;
  assign OUT_ID    = out_id_q;
  assign IN_PKT    = in_pkt_q;

endmodule

// File: tb/tb_ap_acc_arb.sv
// Bench for ap_acc_arb: per-channel operand queues feed a driver, a
// reference model predicts grants and packet sums, and a monitor pops the
// expected results as the DUT hands them out.
module tb_ap_acc_arb;
  import ap_acc_pkg::*;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int RES_W = IDW + 16;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } stim_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic [N-1:0]    drv_valid = '0;
  logic [N-1:0]    drv_last  = '0;
  logic [15:0]     drv_data [N];
  logic [N*16-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [15:0]     out_sum;
  logic [IDW-1:0]  out_id;
  logic [N-1:0]    in_pkt;

  for (genvar i = 0; i < N; i++) begin : g_data
    assign req_data[i*16 +: 16] = drv_data[i];
  end

  ap_acc_arb #(.N_REQ(N)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ_VALID (drv_valid),
    .REQ_DATA  (req_data),
    .REQ_LAST  (drv_last),
    .REQ_READY (req_ready),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_SUM   (out_sum),
    .OUT_ID    (out_id),
    .IN_PKT    (in_pkt)
  );

  // ---------------------------------------------------------------- bookkeeping
  int total = 0;
  int bad   = 0;

  stim_t            stim_q [N][$];
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] res_log[$];
  int               gnt_log[$];
  logic [N-1:0]     acc_seen = '0;
  int               rdy_mode = 1;   // 0 low, 1 high, 2 random
  bit               gaps = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Nibble-wise sum with each nibble's carry thrown away.
  function automatic logic [15:0] apx_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      int s;
      s = int'((a >> (4 * n)) & 16'hF) + int'((b >> (4 * n)) & 16'hF);
      r = r | 16'((s % 16) << (4 * n));
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- driver
  initial begin : drv_p
    stim_t s;
    for (int c = 0; c < N; c++) drv_data[c] = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      for (int c = 0; c < N; c++) begin
        if (acc_seen[c]) begin
          drv_valid[c] = 1'b0;
          acc_seen[c]  = 1'b0;
        end
        if (!drv_valid[c] && stim_q[c].size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
          s            = stim_q[c].pop_front();
          drv_valid[c] = 1'b1;
          drv_data[c]  = s.data;
          drv_last[c]  = s.last;
        end
      end
    end
  end

  // ---------------------------------------------------------------- reference model
  initial begin : model_p
    logic [15:0] m_acc [N];
    logic [N-1:0] m_in_pkt;
    logic [N-1:0] exp_ready;
    logic [15:0] s;
    logic m_out_valid, free;
    int m_ptr, g, c;
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_in_pkt = '0; m_ptr = 0; m_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) m_acc[i] = '0;
        m_in_pkt    = '0;
        m_ptr       = 0;
        m_out_valid = 1'b0;
        exp_q.delete();
        gnt_log.delete();
      end else begin
        free = !m_out_valid || out_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && drv_valid[c] && (!drv_last[c] || free)) g = c;
        end
        exp_ready = (g >= 0) ? N'(1) << g : '0;
        check("req_ready", req_ready, exp_ready);
        check("out_valid", out_valid, m_out_valid);
        check("in_pkt", in_pkt, m_in_pkt);
        if (m_out_valid && out_ready) m_out_valid = 1'b0;
        if (g >= 0) begin
          s = apx_add(m_acc[g], drv_data[g]);
          if (drv_last[g]) begin
            exp_q.push_back({IDW'(g), s});
            m_out_valid = 1'b1;
            m_acc[g]    = '0;
            m_in_pkt[g] = 1'b0;
          end else begin
            m_acc[g]    = s;
            m_in_pkt[g] = 1'b1;
          end
          m_ptr = (g + 1) % N;
          acc_seen[g] = 1'b1;
          gnt_log.push_back(g);
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  initial begin : mon_p
    logic [RES_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got id=%0d sum=0x%h, nothing expected", out_id, out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_id", out_id, e[RES_W-1:16]);
          check("out_sum", out_sum, e[15:0]);
        end
        res_log.push_back({out_id, out_sum});
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic push_op(input int ch, input logic [15:0] d, input logic last);
    stim_q[ch].push_back('{data: d, last: last});
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    drv_valid = '0;
    acc_seen  = '0;
    for (int c = 0; c < N; c++) stim_q[c].delete();
    @(negedge clk);
    check({name, "_rst_out_valid"}, out_valid, 0);
    check({name, "_rst_out_sum"}, out_sum, 0);
    check({name, "_rst_out_id"}, out_id, 0);
    check({name, "_rst_in_pkt"}, in_pkt, 0);
    check({name, "_rst_req_ready"}, req_ready, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    res_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      busy = (drv_valid != 0) || out_valid || (exp_q.size() != 0);
      for (int c = 0; c < N; c++) if (stim_q[c].size() != 0) busy = 1'b1;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic expect_result(input string name, input int id, input logic [15:0] sum);
    int n;
    logic [RES_W-1:0] r;
    n = 0;
    while (res_log.size() == 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (res_log.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no result after %0d cycles, wanted id=%0d sum=0x%h", name, n, id, sum);
    end else begin
      r = res_log.pop_front();
      check({name, "_id"}, r[RES_W-1:16], id);
      check({name, "_sum"}, r[15:0], sum);
    end
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin : main_p
    int n;
    do_reset("init");

    // Single-operand packet passes the operand straight through.
    push_op(0, 16'h1234, 1'b1);
    expect_result("single", 0, 16'h1234);

    // Carry out of the low nibble is lost; in-segment carries are kept.
    push_op(1, 16'h000F, 1'b0);
    push_op(1, 16'h0001, 1'b1);
    expect_result("apx_drop", 1, 16'h0000);
    push_op(1, 16'h0030, 1'b0);
    push_op(1, 16'h0010, 1'b1);
    expect_result("apx_keep", 1, 16'h0040);
    wait_idle("directed");

    // Round-robin with every channel continuously valid.
    do_reset("rr");
    for (int rep = 0; rep < 2; rep++)
      for (int c = 0; c < N; c++) push_op(c, 16'(c + 1), 1'b0);
    n = 0;
    while (gnt_log.size() < 8 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      if (i < gnt_log.size()) check("rr_order", gnt_log[i], i % N);
      else begin
        total++;
        bad++;
        $display("FAIL rr_order: grant %0d missing, got %0d grants", i, gnt_log.size());
      end
    end

    // Backpressure: full output stalls lasts but not non-lasts.
    do_reset("bp");
    rdy_mode = 0;
    push_op(0, 16'h0011, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_valid", out_valid, 1);
    push_op(2, 16'h0022, 1'b1);
    push_op(3, 16'h0033, 1'b0);
    repeat (4) @(negedge clk);
    check("bp_stall_ready", req_ready, 0);
    check("bp_hold_id", out_id, 0);
    check("bp_hold_sum", out_sum, 16'h0011);
    check("bp_ch3_in_pkt", in_pkt, 4'b1000);
    @(posedge clk);
    rdy_mode = 1;
    @(negedge clk);
    check("bp_release_ready", req_ready, 4'b0100);
    @(negedge clk);
    check("bp_reload_valid", out_valid, 1);
    check("bp_reload_id", out_id, 2);
    push_op(3, 16'h0001, 1'b1);
    expect_result("bp_r0", 0, 16'h0011);
    expect_result("bp_r2", 2, 16'h0022);
    expect_result("bp_r3", 3, 16'h0034);
    wait_idle("bp");

    // Interleaved packets on ch0 and ch1.
    do_reset("intl");
    for (int k = 0; k < 3; k++) begin
      push_op(0, 16'h0004, k == 2);
      push_op(1, 16'h0004, k == 2);
    end
    expect_result("intl_r0", 0, 16'h000C);
    expect_result("intl_r1", 1, 16'h000C);
    wait_idle("intl");

    // Reset in the middle of a packet discards the partial sum.
    push_op(0, 16'h0100, 1'b0);
    wait_idle("mid_pre");
    check("mid_in_pkt", in_pkt, 4'b0001);
    do_reset("mid");
    push_op(0, 16'h0001, 1'b1);
    expect_result("mid_after", 0, 16'h0001);
    wait_idle("mid");

    // Random packets with random output backpressure and input gaps.
    rdy_mode = 2;
    gaps = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (stim_q[c].size() < 3 && $urandom_range(0, 2) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            push_op(c, 16'($urandom_range(0, 65535)), k == len - 1);
        end
      end
      res_log.delete();
    end
    rdy_mode = 1;
    wait_idle("random");
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
